// File: rtl/shiftreg_chain_seq_pkg.sv
// Shared types and helpers for the configuration shift-register chain sequencer.
// Chain lengths arrive as one packed parameter; helpers pull out fields and build selects.
package shiftreg_pkg;

    localparam int MAX_CHAINS = 16;
    localparam int MAX_CNT_W  = 32;
    localparam int LENS_MAX_W = MAX_CHAINS * MAX_CNT_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_SHIFT = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Field idx of the packed length vector, each field cntW bits wide.
    function automatic int unsigned chain_len(input logic [LENS_MAX_W-1:0] lens,
                                              input int cntW, input int idx);
        logic [31:0] field;
        logic [31:0] maskBits;
        field    = 32'(lens >> (idx * cntW));
        maskBits = (cntW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cntW) - 32'd1);
        return field & maskBits;
    endfunction

    function automatic int unsigned max_chain_len(input logic [LENS_MAX_W-1:0] lens,
                                                  input int cntW, input int n);
        int unsigned best;
        best = 0;
        for (int i = 0; i < n; i++) begin
            if (chain_len(lens, cntW, i) > best) begin
                best = chain_len(lens, cntW, i);
            end
        end
        return best;
    endfunction

    function automatic logic [MAX_CHAINS-1:0] onehot(input int idx);
        return MAX_CHAINS'(1) << idx;
    endfunction

endpackage

// File: rtl/shiftreg_chain_seq_prio_enc.sv
// Lowest-set-bit finder used to pick the next pending chain.
module shiftreg_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/shiftreg_chain_seq.sv
// Walks the chains selected in a mask, lowest first, shifting each MSB-first and
// pulsing its latch; every output comes straight from a register.
module shiftreg_chain_seq
    import shiftreg_pkg::*;
#(
    parameter int NUM_CHAINS = 2,
    parameter int CNT_W      = 8,
    parameter logic [NUM_CHAINS*CNT_W-1:0] CHAIN_LENS = {8'd16, 8'd88}
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NUM_CHAINS-1:0] i_chain_mask,
    input  logic                  i_abort,
    output logic [NUM_CHAINS-1:0] o_sel,
    output logic                  o_shift_en,
    output logic [CNT_W-1:0]      o_bit_idx,
    output logic [NUM_CHAINS-1:0] o_latch,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_en_fin
);

    localparam int IDX_W = idx_width(NUM_CHAINS);
    localparam logic [LENS_MAX_W-1:0] LENS_EXT = LENS_MAX_W'(CHAIN_LENS);
    localparam int unsigned MAX_LEN = max_chain_len(LENS_EXT, CNT_W, NUM_CHAINS);
    localparam int MIN_CNT_W = $clog2(MAX_LEN) + 1;

    if (NUM_CHAINS < 1 || NUM_CHAINS > MAX_CHAINS) begin : g_bad_num_chains
        $error("NUM_CHAINS must be between 1 and 16");
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w_range
        $error("CNT_W must be between 1 and 32");
    end
    if (CNT_W < MIN_CNT_W) begin : g_cnt_w_too_small
        $error("CNT_W is too narrow for the longest chain");
    end

    state_t                r_state;
    logic [NUM_CHAINS-1:0] r_pending;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_CHAINS-1:0] r_sel;
    logic                  r_shiftEn;
    logic [NUM_CHAINS-1:0] r_latch;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_enFin;

    state_t                w_nextState;
    logic [NUM_CHAINS-1:0] w_nextPending;
    logic [CNT_W-1:0]      w_nextCnt;
    logic [IDX_W-1:0]      w_nextIdx;
    logic [NUM_CHAINS-1:0] w_nextSel;
    logic                  w_nextShiftEn;
    logic [NUM_CHAINS-1:0] w_nextLatch;
    logic                  w_nextDone;
    logic                  w_nextEnFin;

    logic [IDX_W-1:0]      w_encIdx;
    logic                  w_encValid;
    logic [CNT_W-1:0]      w_lenTable [NUM_CHAINS];
    logic [CNT_W-1:0]      w_seekLen;

    for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_len
        assign w_lenTable[g] = CNT_W'(chain_len(LENS_EXT, CNT_W, g));
    end

    shiftreg_prio_enc #(
        .N     (NUM_CHAINS),
        .IDX_W (IDX_W)
    ) u_prioEnc (
        .i_req   (r_pending),
        .o_idx   (w_encIdx),
        .o_valid (w_encValid)
    );

    assign w_seekLen = w_lenTable[w_encIdx];

    // Next-state and next-output logic; pulses default low so they last one cycle.
    always_comb begin
        w_nextState   = r_state;
        w_nextPending = r_pending;
        w_nextCnt     = r_cnt;
        w_nextIdx     = r_idx;
        w_nextSel     = r_sel;
        w_nextShiftEn = 1'b0;
        w_nextLatch   = '0;
        w_nextDone    = 1'b0;
        w_nextEnFin   = r_enFin;

        if (i_abort) begin
            w_nextState   = S_IDLE;
            w_nextPending = '0;
            w_nextCnt     = '0;
            w_nextSel     = '0;
            w_nextEnFin   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_nextPending = i_chain_mask;
                        w_nextEnFin   = 1'b0;
                        w_nextState   = S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (!w_encValid) begin
                        w_nextSel   = '0;
                        w_nextDone  = 1'b1;
                        w_nextState = S_DONE;
                    end else if (w_seekLen == '0) begin
                        w_nextPending[w_encIdx] = 1'b0;
                    end else begin
                        w_nextIdx     = w_encIdx;
                        w_nextSel     = NUM_CHAINS'(onehot(int'(w_encIdx)));
                        w_nextCnt     = w_seekLen - CNT_W'(1);
                        w_nextShiftEn = 1'b1;
                        w_nextState   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        w_nextLatch = r_sel;
                        w_nextState = S_LATCH;
                    end else begin
                        w_nextCnt     = r_cnt - CNT_W'(1);
                        w_nextShiftEn = 1'b1;
                    end
                end
                S_LATCH: begin
                    w_nextPending[r_idx] = 1'b0;
                    w_nextSel            = '0;
                    w_nextState          = S_SEEK;
                end
                S_DONE: begin
                    w_nextEnFin = 1'b1;
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState   = S_IDLE;
                    w_nextPending = '0;
                    w_nextCnt     = '0;
                    w_nextSel     = '0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_sel     <= '0;
            r_shiftEn <= 1'b0;
            r_latch   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_enFin   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pending <= w_nextPending;
            r_cnt     <= w_nextCnt;
            r_idx     <= w_nextIdx;
            r_sel     <= w_nextSel;
            r_shiftEn <= w_nextShiftEn;
            r_latch   <= w_nextLatch;
            r_busy    <= (w_nextState != S_IDLE);
            r_done    <= w_nextDone;
            r_enFin   <= w_nextEnFin;
        end
    end

    assign o_sel      = r_sel;
    assign o_shift_en = r_shiftEn;
    assign o_bit_idx  = r_cnt;
    assign o_latch    = r_latch;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_en_fin   = r_enFin;

endmodule

// File: tb/tb_shiftreg_chain_seq.sv
// Directed bench for shiftreg_chain_seq: default lengths on dutA, {0,5} lengths on dutB.
module tb_shiftreg_chain_seq;

    typedef struct packed {
        logic [1:0] sel;
        logic       shiftEn;
        logic [7:0] bitIdx;
        logic [1:0] latch;
        logic       busy;
        logic       done;
        logic       enFin;
    } outs_t;

    typedef struct packed {
        logic       start;
        logic [1:0] mask;
        logic       abort;
        outs_t      exp;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_abort;
    logic [1:0] i_chain_mask;

    logic [1:0] aSel, aLatch, bSel, bLatch;
    logic       aShift, aBusy, aDone, aFin;
    logic       bShift, bBusy, bDone, bFin;
    logic [7:0] aIdx, bIdx;

    int checks = 0;
    int errors = 0;
    int lensA[2] = '{88, 16};
    int lensB[2] = '{5, 0};
    vec_t vecs[10];

    always #5 i_clk = ~i_clk;

    shiftreg_chain_seq dutA (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_chain_mask (i_chain_mask),
        .i_abort      (i_abort),
        .o_sel        (aSel),
        .o_shift_en   (aShift),
        .o_bit_idx    (aIdx),
        .o_latch      (aLatch),
        .o_busy       (aBusy),
        .o_done       (aDone),
        .o_en_fin     (aFin)
    );

    shiftreg_chain_seq #(
        .NUM_CHAINS (2),
        .CNT_W      (8),
        .CHAIN_LENS ({8'd0, 8'd5})
    ) dutB (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_chain_mask (i_chain_mask),
        .i_abort      (i_abort),
        .o_sel        (bSel),
        .o_shift_en   (bShift),
        .o_bit_idx    (bIdx),
        .o_latch      (bLatch),
        .o_busy       (bBusy),
        .o_done       (bDone),
        .o_en_fin     (bFin)
    );

    function automatic outs_t getOut(input int d);
        outs_t o;
        if (d == 0) begin
            o.sel = aSel; o.shiftEn = aShift; o.bitIdx = aIdx; o.latch = aLatch;
            o.busy = aBusy; o.done = aDone; o.enFin = aFin;
        end else begin
            o.sel = bSel; o.shiftEn = bShift; o.bitIdx = bIdx; o.latch = bLatch;
            o.busy = bBusy; o.done = bDone; o.enFin = bFin;
        end
        return o;
    endfunction

    function automatic vec_t mkVec(input logic st, input logic [1:0] m, input logic ab,
                                   input logic [1:0] sel, input logic sh, input logic [7:0] idx,
                                   input logic [1:0] lat, input logic bsy, input logic dn,
                                   input logic fin);
        vec_t v;
        v.start = st; v.mask = m; v.abort = ab;
        v.exp.sel = sel; v.exp.shiftEn = sh; v.exp.bitIdx = idx; v.exp.latch = lat;
        v.exp.busy = bsy; v.exp.done = dn; v.exp.enFin = fin;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, take one clock edge, land 1ns after it.
    task automatic applyStimulus(input logic st, input logic [1:0] m, input logic ab);
        i_start      = st;
        i_chain_mask = m;
        i_abort      = ab;
        @(posedge i_clk);
        #1;
    endtask

    // Expected per-cycle trace built from the documented schedule: SEEK, then per
    // chain L shift cycles, a latch cycle and a SEEK; a skipped chain costs one SEEK.
    task automatic runSequence(input string name, input int d, input logic [1:0] mask,
                               input int abortAt, input int abortIdx, input int expDone,
                               input int expShifts, input logic [1:0] expLatchOr);
        outs_t expQ[$];
        outs_t e;
        outs_t a;
        int len;
        int doneAt;
        int shifts;
        logic [1:0] latchOr;
        logic [1:0] bitK;

        e = '0; e.busy = 1'b1; expQ.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if (mask[k]) begin
                len  = (d == 0) ? lensA[k] : lensB[k];
                bitK = 2'b01 << k;
                if (len > 0) begin
                    for (int b = len - 1; b >= 0; b--) begin
                        e = '0; e.busy = 1'b1; e.sel = bitK; e.shiftEn = 1'b1; e.bitIdx = 8'(b);
                        expQ.push_back(e);
                    end
                    e = '0; e.busy = 1'b1; e.sel = bitK; e.latch = bitK; expQ.push_back(e);
                end
                e = '0; e.busy = 1'b1; expQ.push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; expQ.push_back(e);
        e = '0; e.enFin = 1'b1; expQ.push_back(e);

        doneAt  = -1;
        shifts  = 0;
        latchOr = '0;
        applyStimulus(1'b1, mask, 1'b0);
        for (int c = 1; c <= expQ.size(); c++) begin
            a = getOut(d);
            if (a.done && doneAt < 0) doneAt = c;
            shifts  += int'(a.shiftEn);
            latchOr |= a.latch;
            checkOutput($sformatf("%s c%0d", name, c), 32'(a), 32'(expQ[c-1]));
            if (c == abortAt) begin
                checkOutput({name, " abort point bitIdx"}, 32'(a.bitIdx), 32'(abortIdx));
                applyStimulus(1'b0, mask, 1'b1);
                for (int p = 0; p < 3; p++) begin
                    a = getOut(d);
                    if (a.done && doneAt < 0) doneAt = c + 1 + p;
                    latchOr |= a.latch;
                    checkOutput($sformatf("%s post-abort c%0d", name, c + 1 + p), 32'(a), 32'(0));
                    if (p < 2) applyStimulus(1'b0, mask, 1'b0);
                end
                break;
            end
            if (c < expQ.size()) applyStimulus(1'b0, mask, 1'b0);
        end
        i_abort = 1'b0;
        checkOutput({name, " done cycle"}, doneAt, expDone);
        checkOutput({name, " shift cycles"}, shifts, expShifts);
        checkOutput({name, " latch union"}, 32'(latchOr), 32'(expLatchOr));
    endtask

    initial begin
        //               st    mask   ab    sel    sh    idx    lat    bsy   dn    fin
        vecs[0] = mkVec(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b0);
        vecs[1] = mkVec(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'd0,  2'b00, 1'b1, 1'b1, 1'b0);
        vecs[2] = mkVec(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b1);
        vecs[3] = mkVec(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b0);
        vecs[4] = mkVec(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b0);
        vecs[5] = mkVec(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b0);
        vecs[6] = mkVec(1'b1, 2'b01, 1'b0, 2'b10, 1'b1, 8'd15, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[7] = mkVec(1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 8'd14, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[8] = mkVec(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b0);
        vecs[9] = mkVec(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b0);

        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_chain_mask = 2'b00;
        #20;
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("reset idle dutA", 32'(getOut(0)), 32'(0));
        checkOutput("reset idle dutB", 32'(getOut(1)), 32'(0));

        $display("[TB] table vectors: mask 0, abort priority, start while busy");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].mask, vecs[i].abort);
            checkOutput($sformatf("vec%0d", i), 32'(getOut(0)), 32'(vecs[i].exp));
        end

        $display("[TB] full sequences on default lengths");
        runSequence("mask11", 0, 2'b11, 0, 0, 110, 104, 2'b11);
        runSequence("mask10", 0, 2'b10, 0, 0, 20, 16, 2'b10);
        runSequence("mask00", 0, 2'b00, 0, 0, 2, 0, 2'b00);

        $display("[TB] abort at chain0 bit 40, then restart");
        runSequence("abort", 0, 2'b11, 49, 40, -1, 48, 2'b00);
        runSequence("restart", 0, 2'b11, 0, 0, 110, 104, 2'b11);

        $display("[TB] zero-length chain is skipped");
        applyStimulus(1'b0, 2'b00, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        runSequence("skip", 1, 2'b11, 0, 0, 10, 5, 2'b01);

        $display("[TB] asynchronous reset mid-sequence");
        applyStimulus(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b11, 1'b0);
        checkOutput("pre-reset shifting", 32'(aShift), 32'(1));
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("async reset dutA", 32'(getOut(0)), 32'(0));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("after reset idle dutA", 32'(getOut(0)), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
